// File: rtl/uplink_serial_capture_pkg.sv
// Shared uplink constants: default geometry, sync pattern and the byte/length
// window offsets that the packet state machine reads from the shift register.
package uplink_serial_capture_pkg;

  localparam int unsigned WIDTH_DEFAULT     = 34;
  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hB9AF2E5C;
  localparam int unsigned BYTE_LSB          = 1;
  localparam int unsigned LEN_LSB           = 2;

  function automatic logic sync_match(input logic [31:0] window,
                                      input logic [31:0] pattern);
    return (window == pattern);
  endfunction

endpackage

// File: rtl/uplink_shift_reg.sv
// WIDTH-bit serial-in shift register; q_o[0] holds the newest bit and the MSB
// falls off the end. Synchronous clear has priority over shifting.
module uplink_shift_reg
  import uplink_serial_capture_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             sclr_i,
  input  logic             d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] shift_q;

  // Next shift value: newest bit enters at bit 0
  always_comb begin
    shift_d = {shift_q[WIDTH-2:0], d_i};
  end

  // Shift register storage
  always_ff @(posedge clk_i) begin
    if (sclr_i) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign q_o = shift_q;

endmodule

// File: rtl/uplink_serial_capture.sv
// Uplink lane capture front end: serial shift register, registered sync-word
// detector on the low 32 bits, and a clear-dominant sticky request flag.
module uplink_serial_capture
  import uplink_serial_capture_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEFAULT,
  parameter logic [31:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             serial_i,
  output logic [WIDTH-1:0] q_o,
  output logic             sync_found_o,
  input  logic             flag_set_i,
  input  logic             flag_clr_i,
  output logic             flag_o
);

  logic [WIDTH-1:0] shift_s;
  logic             sync_found_d;
  logic             sync_found_q;
  logic             flag_d;
  logic             flag_q;

  uplink_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .clk_i  (clk_i),
    .sclr_i (rst_i),
    .d_i    (serial_i),
    .q_o    (shift_s)
  );

  // Compare uses pre-edge contents; upper bits beyond 31 are don't-care
  always_comb begin
    sync_found_d = sync_match(shift_s[31:0], SYNC_WORD);
    flag_d       = flag_q;
    if (flag_clr_i) begin
      flag_d = 1'b0;
    end else if (flag_set_i) begin
      flag_d = 1'b1;
    end else begin
      flag_d = flag_q;
    end
  end

  // Detector and sticky flag registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_found_q <= 1'b0;
      flag_q       <= 1'b0;
    end else begin
      sync_found_q <= sync_found_d;
      flag_q       <= flag_d;
    end
  end

  assign q_o          = shift_s;
  assign sync_found_o = sync_found_q;
  assign flag_o       = flag_q;

endmodule

// File: tb/tb_uplink_serial_capture.sv
// Randomized + directed bench for uplink_serial_capture with a bit-history
// reference model feeding a scoreboard drained by a negedge monitor.
module tb_uplink_serial_capture;

  localparam int          W    = 34;
  localparam logic [31:0] SYNC = 32'hB9AF2E5C;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         serial_i = 1'b0;
  logic         flag_set_i = 1'b0;
  logic         flag_clr_i = 1'b0;
  logic [W-1:0] q_o;
  logic         sync_found_o;
  logic         flag_o;

  typedef struct {
    logic [W-1:0] q;
    logic         sync;
    logic         flag;
  } exp_t;

  exp_t sb[$];
  bit   hist[$];
  logic m_sync = 1'b0;
  logic m_flag = 1'b0;
  int   total = 0;
  int   bad = 0;

  uplink_serial_capture #(
    .WIDTH     (W),
    .SYNC_WORD (SYNC)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .serial_i     (serial_i),
    .q_o          (q_o),
    .sync_found_o (sync_found_o),
    .flag_set_i   (flag_set_i),
    .flag_clr_i   (flag_clr_i),
    .flag_o       (flag_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // True when the last 32 received bits (oldest first) spell the sync word
  function automatic logic hist_has_sync();
    logic [31:0] w;
    int n;
    n = hist.size();
    if (n < 32) return 1'b0;
    w = 32'h0;
    for (int i = n - 32; i < n; i++) w = {w[30:0], 1'(hist[i])};
    return (w == SYNC);
  endfunction

  function automatic logic [W-1:0] hist_to_q();
    logic [W-1:0] q;
    int n;
    n = hist.size();
    q = '0;
    for (int k = 0; k < W; k++) begin
      if (k < n) q[k] = hist[n-1-k];
    end
    return q;
  endfunction

  task automatic step(input logic ser, input logic set, input logic clr, input logic rst);
    exp_t e;
    @(negedge clk_i);
    serial_i   = ser;
    flag_set_i = set;
    flag_clr_i = clr;
    rst_i      = rst;
    @(posedge clk_i);
    #1;
    if (rst) begin
      hist.delete();
      m_sync = 1'b0;
      m_flag = 1'b0;
    end else begin
      m_sync = hist_has_sync();
      hist.push_back(ser);
      if (hist.size() > W) void'(hist.pop_front());
      if (clr) m_flag = 1'b0;
      else if (set) m_flag = 1'b1;
    end
    e.q = hist_to_q();
    e.sync = m_sync;
    e.flag = m_flag;
    sb.push_back(e);
  endtask

  task automatic send_bits(input logic [31:0] word, input int nbits, input int first);
    for (int i = first; i > first - nbits; i--) step(word[i], 1'b0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: every cycle presents a full output set
  always @(negedge clk_i) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_q", 64'(q_o), 64'(e.q));
      chk("sb_sync", 64'(sync_found_o), 64'(e.sync));
      chk("sb_flag", 64'(flag_o), 64'(e.flag));
    end
  end

  initial begin
    logic [7:0]  b2;
    logic [31:0] miss;
    b2   = 8'hB2;
    miss = 32'hB9AF2E5D;

    // Reset after a long run of ones
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("reset_q", 64'(q_o), 64'h0);
    chk("reset_sync", 64'(sync_found_o), 64'h0);
    chk("reset_flag", 64'(flag_o), 64'h0);

    // Byte ordering
    for (int i = 7; i >= 0; i--) step(b2[i], 1'b0, 1'b0, 1'b0);
    chk("byte_q7_0", 64'(q_o[7:0]), 64'hB2);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("byte_q8_1", 64'(q_o[8:1]), 64'hB2);

    // Sync detect timing
    send_bits(SYNC, 32, 31);
    chk("sync_window", 64'(q_o[31:0]), 64'(SYNC));
    chk("sync_not_yet", 64'(sync_found_o), 64'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("sync_rise", 64'(sync_found_o), 64'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("sync_fall", 64'(sync_found_o), 64'h0);

    // Near miss, then high bits set ahead of a real sync word
    send_bits(miss, 32, 31);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(SYNC, 32, 31);
    chk("hibits_q", 64'(q_o[33:32]), 64'h3);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("hibits_sync", 64'(sync_found_o), 64'h1);

    // Sticky flag
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("flag_hold", 64'(flag_o), 64'h1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("flag_clr_wins", 64'(flag_o), 64'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("flag_reset_after_clr", 64'(flag_o), 64'h1);

    // Reset in the middle of a sync word
    send_bits(SYNC, 20, 31);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(SYNC, 12, 11);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst_nosync", 64'(sync_found_o), 64'h0);
    send_bits(SYNC, 32, 31);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst_resend", 64'(sync_found_o), 64'h1);

    // Random traffic with occasional injected sync words
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        send_bits(SYNC, 32, 31);
      end else begin
        step(1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 99) == 0));
      end
    end

    @(negedge clk_i);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uplink_serial_capture.md
Name: uplink_serial_capture

Overview:
- Bit-serial capture front end for one uplink lane: a WIDTH-bit synchronous shift register, a registered sync-word detector, and a sticky capture flag with synchronous clear.
- Sits between the raw serial pins and the uplink packet state machine.
- The state machine reads byte windows and length fields from the shift register contents.
- The state machine uses the sticky flag to latch an asynchronous request level, and clears it when it has consumed the request.

Parameters:
- WIDTH, 34: shift register length in bits; legal values are 33 or more.
- SYNC_WORD, 32'hB9AF2E5C: sync pattern compared against q_o[31:0].

Ports:
- clk_i  in  1  serial data clock; all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- serial_i  in  1  serial data bit.
- q_o  out  WIDTH  shift register contents; q_o[0] is the newest bit.
- sync_found_o  out  1  registered flag: q_o[31:0] equalled SYNC_WORD at the previous edge.
- flag_set_i  in  1  sticky-flag set request; level-sampled each edge.
- flag_clr_i  in  1  sticky-flag synchronous clear.
- flag_o  out  1  sticky flag.

Behaviour:
- Reset (rst_i=1 at an edge):
  - q_o <= 0, sync_found_o <= 0, flag_o <= 0.
  - Reset overrides all other inputs.
- Shift:
  - Every non-reset edge: q_o <= {q_o[WIDTH-2:0], serial_i}.
  - No enable. The MSB is discarded.
  - A bit presented before edge n appears at q_o[0] after edge n and at q_o[k] after edge n+k.
- Byte and word windows:
  - After 8 consecutive bits, the byte sits in q_o[7:0], with the first-received bit at q_o[7].
  - Consumers may sample any window, e.g. q_o[8:1] one edge later, or the 32-bit field q_o[33:2].
  - The block imposes no alignment.
- Sync detect:
  - sync_found_o <= (q_o[31:0] == SYNC_WORD). The compare uses pre-edge q_o.
  - sync_found_o rises one edge after the 32nd sync bit lands in q_o[0].
  - It stays high only while the match persists; normally that is a one-cycle pulse.
  - Bits q_o[WIDTH-1:32] are ignored by the compare.
- Sticky flag, non-reset edge:
  - If flag_clr_i: flag_o <= 0.
  - Else if flag_set_i: flag_o <= 1.
  - Else flag_o holds.
  - Clear wins over a simultaneous set; set is re-evaluated on the next edge.
  - flag_set_i is not synchronized internally. The instantiating block either double-flops it or guarantees it is stable around edges.
- All outputs are registered; no combinational input-to-output paths.
- Reset mid-stream: all history is lost. A sync word must be fully re-received (32 bits) before sync_found_o can assert.

Decomposition:
- Shared uplink package: SYNC_WORD default, WIDTH default (34), and byte-window offset constants (BYTE_LSB=1, LEN_LSB=2).
- One sub-module, uplink_shift_reg: WIDTH-parameterized shift register with sclr and q output.
- Sync compare and sticky flag stay in the top.

Test Plan:
- Reset: drive serial_i=1 for 40 clocks, assert rst_i one edge -> q_o=0, sync_found_o=0, flag_o=0 the following cycle.
- Shift order: after reset, shift bits 1,0,1,1,0,0,1,0 MSB-first -> q_o[7:0]=8'hB2; one more 0 bit -> q_o[8:1]=8'hB2.
- Sync detect: shift 32'hB9AF2E5C MSB-first -> sync_found_o=0 at the edge where q_o[31:0] first equals B9AF2E5C; =1 after the next edge; =0 one edge after a further non-matching bit.
- Near-miss and high bits: shift 32'hB9AF2E5D -> sync_found_o never asserts. Prefix q_o[33:32] with 2'b11 before the correct word -> still asserts.
- Sticky flag: pulse flag_set_i one cycle -> flag_o=1 and holds for 10 cycles. Assert set and clr together -> flag_o=0. Release clr with set held -> flag_o=1 next edge.
- Reset mid-sync: apply rst_i after 20 sync bits, then send the remaining 12 -> sync_found_o stays 0. A full 32-bit resend -> asserts.
